// File: rtl/ai_sched_pkg.sv
// Shared types and constants for the AI car spawn scheduler.
package ai_sched_pkg;

  localparam int CAR_IDX_W = 4;

  localparam logic [10:0] LANE_X [4] = '{11'd140, 11'd180, 11'd220, 11'd260};

  typedef enum logic [1:0] {
    IDLE,
    PICK,
    GRANT,
    COOLDOWN
  } sched_state_e;

  typedef struct packed {
    logic                 valid;
    logic [CAR_IDX_W-1:0] car;
  } lane_owner_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set request at or after start, wrapping.
module rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W-1:0] j;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = W'((32'(start) + i) % N);
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/ai_spawn_scheduler.sv
// Per-frame spawn scheduler: round-robin car choice, random-start lane probe,
// lane ownership tracking and frame-count cooldown between grants.
module ai_spawn_scheduler
  import ai_sched_pkg::*;
#(
  parameter int NUM_CARS         = 4,
  parameter int NUM_LANES        = 4,
  parameter int SPAWN_GAP_FRAMES = 16
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 frame_start,
  input  logic [10:0]          random,
  input  logic [NUM_CARS-1:0]  spawn_req,
  input  logic [NUM_CARS-1:0]  lane_release,
  output logic [NUM_CARS-1:0]  spawn_grant,
  output logic [1:0]           spawn_lane,
  output logic [10:0]          spawn_x,
  output logic [NUM_LANES-1:0] lane_busy
);

  localparam int CAR_W  = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CD_W   = (SPAWN_GAP_FRAMES > 0) ? $clog2(SPAWN_GAP_FRAMES + 1) : 1;
  localparam logic [LANE_W:0] LAST_PROBE = (LANE_W + 1)'(NUM_LANES - 1);

  sched_state_e          state_q, state_d;
  logic [CAR_W-1:0]      car_q, rr_ptr_q, pick_idx;
  logic                  pick_found;
  logic [LANE_W-1:0]     probe_q;
  logic [LANE_W:0]       probe_cnt_q;
  logic [CD_W-1:0]       cooldown_q;
  lane_owner_t           owner_q [NUM_LANES];
  lane_owner_t           owner_d [NUM_LANES];
  logic [NUM_LANES-1:0]  busy;
  logic                  start_search, probe_free;
  logic [CAR_IDX_W-1:0]  car_ext;
  logic                  unused_random;

  assign unused_random = ^random[10:LANE_W];
  assign car_ext       = CAR_IDX_W'(car_q);
  assign lane_busy     = busy;
  assign probe_free    = !busy[probe_q];
  assign start_search  = frame_start && pick_found && !(&busy) && (cooldown_q == '0);

  rr_pick #(
    .N(NUM_CARS),
    .W(CAR_W)
  ) u_rr_pick (
    .req  (spawn_req),
    .start(rr_ptr_q),
    .idx  (pick_idx),
    .found(pick_found)
  );

  always_comb begin
    busy = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) busy[l] = owner_q[l].valid;
  end

  // Releases are applied first so a grant write to the same lane overrides them.
  always_comb begin
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      owner_d[l] = owner_q[l];
      for (int unsigned c = 0; c < NUM_CARS; c++) begin
        if (lane_release[c] && owner_q[l].valid && owner_q[l].car == CAR_IDX_W'(c))
          owner_d[l].valid = 1'b0;
      end
      if (state_q == GRANT) begin
        if (probe_q == LANE_W'(l)) begin
          owner_d[l].valid = 1'b1;
          owner_d[l].car   = car_ext;
        end else if (owner_d[l].valid && owner_d[l].car == car_ext) begin
          owner_d[l].valid = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_search) state_d = PICK;
      PICK: begin
        if (probe_free)                     state_d = GRANT;
        else if (probe_cnt_q == LAST_PROBE) state_d = IDLE;
      end
      GRANT:    state_d = (SPAWN_GAP_FRAMES == 0) ? IDLE : COOLDOWN;
      COOLDOWN: if (frame_start && cooldown_q <= CD_W'(1)) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Grant outputs are loaded on the PICK->GRANT edge so they are valid during GRANT.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      car_q       <= '0;
      rr_ptr_q    <= '0;
      probe_q     <= '0;
      probe_cnt_q <= '0;
      cooldown_q  <= '0;
      spawn_grant <= '0;
      spawn_lane  <= '0;
      spawn_x     <= '0;
      for (int unsigned l = 0; l < NUM_LANES; l++) owner_q[l] <= '0;
    end else begin
      spawn_grant <= '0;
      for (int unsigned l = 0; l < NUM_LANES; l++) owner_q[l] <= owner_d[l];
      case (state_q)
        IDLE: begin
          if (start_search) begin
            car_q       <= pick_idx;
            probe_q     <= random[LANE_W-1:0];
            probe_cnt_q <= '0;
          end
        end
        PICK: begin
          if (probe_free) begin
            spawn_grant <= NUM_CARS'(1) << car_q;
            spawn_lane  <= 2'(probe_q);
            spawn_x     <= LANE_X[probe_q];
          end else begin
            probe_q     <= probe_q + 1'b1;
            probe_cnt_q <= probe_cnt_q + 1'b1;
          end
        end
        GRANT: begin
          rr_ptr_q   <= (car_q == CAR_W'(NUM_CARS - 1)) ? '0 : car_q + 1'b1;
          cooldown_q <= CD_W'(SPAWN_GAP_FRAMES);
        end
        COOLDOWN: begin
          if (frame_start && cooldown_q != '0) cooldown_q <= cooldown_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ai_spawn_scheduler.md
# ai_spawn_scheduler

Per-frame scheduler that hands road lanes to the AI cars when they respawn at the top of the screen. Cars that have left the screen raise a spawn request. The block arbitrates round-robin between requesting cars and starts its lane search at a random lane. It grants at most one car per frame, with a frame-count cooldown between grants, and tracks lane ownership so two live cars never share a lane. It sits between the random-number source and the AI car instances, which load the granted x position on their respawn.

## Interface
Parameters:
- NUM_CARS, 4, number of AI car requesters.
- NUM_LANES, 4, number of lanes; must be a power of two.
- SPAWN_GAP_FRAMES, 16, frames of cooldown after each grant; 0 means no cooldown.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the start of each video frame.
- random  in  11  free-running random value, sampled only when a search starts.
- spawn_req  in  NUM_CARS  level per car; held high until that car's grant.
- lane_release  in  NUM_CARS  one-cycle pulse per car; the car has cleared the spawn zone, so its lane may be reused.
- spawn_grant  out  NUM_CARS  one-hot, one-cycle pulse selecting the car to respawn.
- spawn_lane  out  2  granted lane index; valid while spawn_grant is nonzero.
- spawn_x  out  11  LANE_X[spawn_lane]; valid while spawn_grant is nonzero.
- lane_busy  out  NUM_LANES  registered lane-occupancy vector.

## Operation
- State: lane_owner[l] holds a valid bit and a car index per lane. Also kept: rr_ptr (car index), cooldown (frame counter), FSM.
- FSM states: IDLE, PICK, GRANT, COOLDOWN.
- IDLE:
  - Starts a search on frame_start when all three hold: spawn_req is nonzero, at least one lane is free, and cooldown is 0.
  - On start, latches the car: the first requesting index at or after rr_ptr, wrapping.
  - On start, latches probe = random mod NUM_LANES (the two LSBs).
  - Goes to PICK.
- PICK: one lane probed per cycle.
  - If lane probe is free, go to GRANT.
  - Otherwise probe = probe+1 mod NUM_LANES.
  - If the lanes become fully busy during PICK (no owner bit free after NUM_LANES probes), abort to IDLE with no grant and rr_ptr unchanged.
- GRANT (one cycle):
  - spawn_grant[car]=1; drive spawn_lane and spawn_x.
  - Write lane_owner[probe] = {valid, car}. Any other lane owned by that car is cleared in the same cycle.
  - rr_ptr = car+1 mod NUM_CARS.
  - Load cooldown = SPAWN_GAP_FRAMES, then go to COOLDOWN; if SPAWN_GAP_FRAMES=0, go to IDLE.
- COOLDOWN:
  - cooldown decrements on each frame_start.
  - When it reaches 0, go to IDLE. The search can start no earlier than the next frame_start after that.
- Release:
  - lane_release[c] clears every lane owned by car c. It is applied in every state.
  - A release for a car that owns no lane is ignored.
  - If a release and a GRANT write hit the same lane in the same cycle, the grant write wins.
  - During PICK, a lane freed by release is visible from the next probe onward.
- Requests:
  - The latched car receives its grant even if its spawn_req drops during PICK; cars must not drop the request before the grant.
  - Requests seen mid-frame wait for the next frame_start.
- Reset (asynchronous, applies in any state):
  - State returns to IDLE; any search in flight is discarded.
  - All lanes are cleared (lane_owner valid bits = 0).
  - rr_ptr = 0, cooldown = 0.
  - spawn_grant = 0, spawn_lane = 0, spawn_x = 0, lane_busy = 0.

## Timing
- All outputs are registered.
- Latency: frame_start at cycle T, with k probes (1..NUM_LANES) needed, gives the grant at cycle T+1+k.
  - Best case T+2; worst case T+1+NUM_LANES.
- Throughput: at most one grant per frame, and at most one per SPAWN_GAP_FRAMES+1 frames when SPAWN_GAP_FRAMES > 0.
- lane_busy updates one cycle after the GRANT write or the release pulse.
- spawn_x and spawn_lane hold their last values when no grant is active. Consumers qualify them with spawn_grant.

## Structure
- Package ai_sched_pkg holds:
  - LANE_X: NUM_LANES × 11-bit lane positions, {140,180,220,260}.
  - The FSM state enum {IDLE, PICK, GRANT, COOLDOWN}.
  - The lane_owner struct type (valid, car index).
- Sub-module rr_pick: combinational round-robin first-set finder, with inputs req vector and start index, and outputs index and found.

## Test plan
- Reset, then spawn_req=4'b0001, random=0, frame_start → spawn_grant=0001 at T+2; spawn_lane=0; spawn_x=140; lane_busy=0001.
- Lanes 2 and 3 busy, random=2, car 1 requests → three probes; grant at T+4 on lane 0, spawn_x=140.
- spawn_req=4'b1111 with rr_ptr=2 → grants go to cars 2, 3, 0, 1 in successive eligible frames. Each grant comes SPAWN_GAP_FRAMES+1 frames after the previous one, and no lane is assigned twice.
- All four lanes owned, then lane_release[3] → search starts on the next frame_start; grant lands in car 3's former lane; lane_busy returns to 1111.
- Assert resetN low during PICK → no grant issued; all outputs 0. After release of reset, the first frame_start with a request behaves as from clean reset.
- SPAWN_GAP_FRAMES=0 with a continuous request → one grant on every frame while lanes are free.
